// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB pipeline register and write-back datapath.
package wb_pkg;

  // Write-back source select carried down from decode.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  // Load size/sign encodings (funct3 of the LOAD opcode).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Architectural register x0 is hard-wired to zero and never written.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True for the funct3 codes that name a real load.
  function automatic logic is_load_funct3(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword/word out of the
// raw memory word, extends it to XLEN, and flags misaligned or illegal loads.
module load_align_unit
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] value,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Sign-extend a byte to XLEN.
  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
    return XLEN'(b);
  endfunction

  // Zero-extend a byte to XLEN.
  function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
    return XLEN'(b);
  endfunction

  // Sign-extend a halfword to XLEN.
  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
    return XLEN'(h);
  endfunction

  // Zero-extend a halfword to XLEN.
  function automatic logic [XLEN-1:0] zext16(input logic [15:0] h);
    return XLEN'(h);
  endfunction

  // Sign-extend a word to XLEN (identity when XLEN is 32).
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] w);
    return XLEN'(w);
  endfunction

  // Lane selection: byte by the full offset, halfword by offset bit 1 only.
  assign byte_sel = raw[{off, 3'b000} +: 8];
  assign half_sel = raw[{off[1], 4'b0000} +: 16];

  // Decode load size/sign into the extended value and the fault flags.
  always_comb begin
    value      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  value = sext8(byte_sel);
      F3_LBU: value = zext8(byte_sel);
      F3_LH: begin
        value      = sext16(half_sel);
        misaligned = off[0];
      end
      F3_LHU: begin
        value      = zext16(half_sel);
        misaligned = off[0];
      end
      F3_LW: begin
        value      = sext32(raw[31:0]);
        misaligned = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back datapath: captures MEM results, aligns
// loads, selects the write-back value, drives the register-file write port and the
// forwarding tap, and counts retired instructions.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_result_src,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_read_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             wb_fault,
  output logic [CNT_W-1:0] instret
);

  // MEM/WB stage registers; fresh marks the first cycle an instruction sits in WB.
  logic              vld_p1;
  logic              fresh_p1;
  logic              reg_write_p1;
  logic [4:0]        rd_p1;
  result_src_e       src_p1;
  logic [2:0]        funct3_p1;
  logic [XLEN-1:0]   alu_p1;
  logic [XLEN-1:0]   rdata_p1;
  logic [XLEN-1:0]   pc4_p1;
  logic [CNT_W-1:0]  instret_q;

  logic [XLEN-1:0]   load_value;
  logic              load_mis;
  logic              load_ill;
  logic [XLEN-1:0]   sel_value;
  logic              src_fault;
  logic              writes_rd;

  // Capture MEM results with priority rst > flush > stall > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      fresh_p1     <= 1'b0;
      reg_write_p1 <= 1'b0;
      rd_p1        <= '0;
      src_p1       <= RES_ALU;
      funct3_p1    <= '0;
      alu_p1       <= '0;
      rdata_p1     <= '0;
      pc4_p1       <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      fresh_p1 <= 1'b0;
    end else if (stall) begin
      fresh_p1 <= 1'b0;
    end else begin
      vld_p1       <= mem_valid;
      fresh_p1     <= mem_valid;
      reg_write_p1 <= mem_reg_write;
      rd_p1        <= mem_rd;
      src_p1       <= result_src_e'(mem_result_src);
      funct3_p1    <= mem_funct3;
      alu_p1       <= mem_alu_result;
      rdata_p1     <= mem_read_data;
      pc4_p1       <= mem_pc_plus4;
    end
  end

  // Count each instruction once, on the edge that ends its first WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (vld_p1 && fresh_p1) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // ---- WB stage: load alignment, result select, write-port qualification ----
  load_align_unit #(
    .XLEN(XLEN)
  ) u_align (
    .funct3    (funct3_p1),
    .off       (alu_p1[1:0]),
    .raw       (rdata_p1),
    .value     (load_value),
    .misaligned(load_mis),
    .illegal   (load_ill)
  );

  // Select the write-back value; load faults only matter when the load is the source.
  always_comb begin
    sel_value = '0;
    src_fault = 1'b0;
    case (src_p1)
      RES_ALU: sel_value = alu_p1;
      RES_MEM: begin
        sel_value = load_value;
        src_fault = load_mis | load_ill;
      end
      RES_PC4: sel_value = pc4_p1;
      default: src_fault = 1'b1;
    endcase
  end

  // A faulting instruction retires but never touches the register file.
  assign writes_rd = vld_p1 & reg_write_p1 & (rd_p1 != REG_ZERO) & ~src_fault;

  // Writes happen once; forwarding stays up for the whole stall.
  assign rf_we     = writes_rd & fresh_p1;
  assign rf_addr   = vld_p1 ? rd_p1 : '0;
  assign rf_wdata  = vld_p1 ? sel_value : '0;
  assign fwd_valid = writes_rd;
  assign fwd_rd    = rf_addr;
  assign fwd_data  = rf_wdata;
  assign wb_fault  = vld_p1 & src_fault;
  assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a behavioural WB model predicts each
// cycle's outputs and a negedge monitor compares them against two instances
// (full-width counter and a 3-bit counter that wraps quickly).
module tb_writeback_stage;
  import wb_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall, flush, mem_valid, mem_reg_write;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_result_src;
  logic [2:0]       mem_funct3;
  logic [XLEN-1:0]  mem_alu_result, mem_read_data, mem_pc_plus4;

  logic             rf_we, fwd_valid, wb_fault;
  logic [4:0]       rf_addr, fwd_rd;
  logic [XLEN-1:0]  rf_wdata, fwd_data;
  logic [CNT_W-1:0] instret;

  logic             s_rf_we, s_fwd_valid, s_wb_fault;
  logic [4:0]       s_rf_addr, s_fwd_rd;
  logic [XLEN-1:0]  s_rf_wdata, s_fwd_data;
  logic [SW-1:0]    s_instret;

  writeback_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_fault(wb_fault), .instret(instret)
  );

  writeback_stage #(.XLEN(XLEN), .CNT_W(SW)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4),
    .rf_we(s_rf_we), .rf_addr(s_rf_addr), .rf_wdata(s_rf_wdata),
    .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
    .wb_fault(s_wb_fault), .instret(s_instret)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    bit          chk_data;
    logic        fault;
    logic        fwd;
    logic [63:0] count;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model of what currently sits in WB.
  bit          m_valid, m_fresh, m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_rdat, m_pc;
  logic [63:0] m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Load result from first principles: shift the word down to the addressed lane.
  function automatic void ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] word, output logic [31:0] val,
                                   output bit bad);
    int unsigned off = addr % 4;
    int unsigned b   = (word >> (8 * off)) & 32'hFF;
    int unsigned h   = (word >> (16 * (off / 2))) & 32'hFFFF;
    val = 0;
    bad = 0;
    case (f3)
      3'd0: val = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: val = b;
      3'd1: begin val = (h >= 32768) ? (h | 32'hFFFF_0000) : h; bad = (off % 2) != 0; end
      3'd5: begin val = h; bad = (off % 2) != 0; end
      3'd2: begin val = word; bad = (off != 0); end
      default: bad = 1;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [31:0] v = 0;
    bit flt = 0;
    bit wr;
    case (m_src)
      2'd0: v = m_alu;
      2'd1: ref_load(m_f3, m_alu, m_rdat, v, flt);
      2'd2: v = m_pc;
      default: flt = 1;
    endcase
    wr         = m_valid && m_rw && (m_rd != 0) && !flt;
    e.cyc      = 0;
    e.fault    = m_valid && flt;
    e.fwd      = wr;
    e.we       = wr && m_fresh;
    e.addr     = m_valid ? m_rd : 5'd0;
    e.wdata    = m_valid ? v : 32'd0;
    e.chk_data = !(m_valid && flt);
    e.count    = m_count;
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_fresh = 0; m_rw = 0; m_rd = 0; m_src = 0; m_f3 = 0;
    m_alu = 0; m_rdat = 0; m_pc = 0; m_count = 0;
  endtask

  // Present one cycle of MEM inputs, advance the model across the edge, queue the
  // expected WB outputs for the next cycle, and return 1 time unit after that edge.
  task automatic drive(input bit fl, input bit st, input bit mv, input bit rw,
                       input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc);
    exp_t e;
    flush = fl; stall = st; mem_valid = mv; mem_reg_write = rw; mem_rd = rd;
    mem_result_src = src; mem_funct3 = f3; mem_alu_result = alu;
    mem_read_data = rdat; mem_pc_plus4 = pc;
    if (m_valid && m_fresh) m_count = m_count + 1;
    if (fl) begin
      m_valid = 0; m_fresh = 0;
    end else if (st) begin
      m_fresh = 0;
    end else begin
      m_valid = mv; m_fresh = mv; m_rw = rw; m_rd = rd; m_src = src; m_f3 = f3;
      m_alu = alu; m_rdat = rdat; m_pc = pc;
    end
    e = predict();
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_rf_addr"}, rf_addr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
    check({tag, "_fwd_valid"}, fwd_valid, 0);
    check({tag, "_fwd_rd"}, fwd_rd, 0);
    check({tag, "_fwd_data"}, fwd_data, 0);
    check({tag, "_wb_fault"}, wb_fault, 0);
    check({tag, "_instret"}, instret, 0);
    check({tag, "_small_instret"}, s_instret, 0);
  endtask

  // Assert reset between edges (after this cycle's monitor sample) and check it bites at once.
  task automatic reset_mid();
    #5;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare both instances against the expectation queued for this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      check("stale_expectation_cycle", 64'(exp_q[0].cyc), 64'(cyc));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("rf_we", rf_we, e.we);
      check("rf_addr", rf_addr, e.addr);
      check("fwd_valid", fwd_valid, e.fwd);
      check("fwd_rd", fwd_rd, e.addr);
      check("wb_fault", wb_fault, e.fault);
      check("instret", instret, e.count);
      check("small_rf_we", s_rf_we, e.we);
      check("small_rf_addr", s_rf_addr, e.addr);
      check("small_fwd_valid", s_fwd_valid, e.fwd);
      check("small_fwd_rd", s_fwd_rd, e.addr);
      check("small_wb_fault", s_wb_fault, e.fault);
      check("small_instret_wrap", s_instret, 64'(e.count[SW-1:0]));
      if (e.chk_data) begin
        check("rf_wdata", rf_wdata, e.wdata);
        check("fwd_data", fwd_data, e.wdata);
        check("small_rf_wdata", s_rf_wdata, e.wdata);
        check("small_fwd_data", s_fwd_data, e.wdata);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [63:0] i0;
    logic [4:0]  rrd;
    logic [1:0]  rsrc;
    logic [2:0]  rf3;
    int          r;
    stall = 0; flush = 0; mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
    mem_result_src = 0; mem_funct3 = 0; mem_alu_result = 0;
    mem_read_data = 0; mem_pc_plus4 = 0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // ALU write to x5 and the retire count following it.
    drive(0, 0, 1, 1, 5'd5, RES_ALU, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
    check("alu_rf_we", rf_we, 1);
    check("alu_rf_addr", rf_addr, 5);
    check("alu_rf_wdata", rf_wdata, 32'h1234);
    check("alu_instret_before", instret, 0);
    drive(0, 0, 1, 1, 5'd3, RES_MEM, F3_LB, 32'h0000_0102, 32'h80FF_7F01, 32'h0);
    check("alu_instret_after", instret, 1);
    check("lb_off2", rf_wdata, 32'hFFFF_FFFF);
    drive(0, 0, 1, 1, 5'd3, RES_MEM, F3_LBU, 32'h0000_0103, 32'h80FF_7F01, 32'h0);
    check("lbu_off3", rf_wdata, 32'h0000_0080);
    drive(0, 0, 1, 1, 5'd3, RES_MEM, F3_LH, 32'h0000_0102, 32'h80FF_7F01, 32'h0);
    check("lh_off2", rf_wdata, 32'hFFFF_80FF);
    drive(0, 0, 1, 1, 5'd3, RES_MEM, F3_LHU, 32'h0000_0100, 32'h80FF_7F01, 32'h0);
    check("lhu_off0", rf_wdata, 32'h0000_7F01);

    // Misaligned LW and illegal funct3 still retire but never write.
    drive(0, 0, 1, 1, 5'd4, RES_MEM, F3_LW, 32'h0000_1001, 32'h1234_5678, 32'h0);
    check("lw_mis_fault", wb_fault, 1);
    check("lw_mis_we", rf_we, 0);
    i0 = instret;
    drive(0, 0, 1, 1, 5'd4, RES_MEM, 3'b011, 32'h0000_2000, 32'h1234_5678, 32'h0);
    check("lw_mis_retired", instret, i0 + 1);
    check("illegal_f3_fault", wb_fault, 1);
    check("illegal_f3_we", rf_we, 0);

    // x0 is never written; link value goes through.
    drive(0, 0, 1, 1, 5'd0, RES_ALU, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    check("x0_we", rf_we, 0);
    check("x0_fwd", fwd_valid, 0);
    drive(0, 0, 1, 1, 5'd1, RES_PC4, 3'd0, 32'h0, 32'h0, 32'h0000_0104);
    check("pc4_wdata", rf_wdata, 32'h104);

    // Stall: write only in the first WB cycle, forward throughout, count once.
    drive(0, 0, 1, 1, 5'd7, RES_ALU, 3'd0, 32'h0000_0077, 32'h0, 32'h0);
    check("stall_first_we", rf_we, 1);
    check("stall_first_fwd", fwd_valid, 1);
    i0 = instret;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 1, 5'd8, RES_ALU, 3'd0, 32'h0000_0088, 32'h0, 32'h0);
      check("stall_hold_we", rf_we, 0);
      check("stall_hold_fwd", fwd_valid, 1);
      check("stall_hold_rd", fwd_rd, 7);
      check("stall_hold_data", fwd_data, 32'h77);
    end
    drive(0, 0, 0, 0, 5'd0, RES_ALU, 3'd0, 32'h0, 32'h0, 32'h0);
    check("stall_count_once", instret, i0 + 1);

    // Flush beats stall and discards the incoming instruction.
    drive(0, 0, 1, 1, 5'd9, RES_ALU, 3'd0, 32'h0000_0099, 32'h0, 32'h0);
    drive(1, 1, 1, 1, 5'd10, RES_ALU, 3'd0, 32'h0000_00AA, 32'h0, 32'h0);
    check("flush_we", rf_we, 0);
    check("flush_fwd", fwd_valid, 0);
    check("flush_addr", rf_addr, 0);

    // Asynchronous reset while a write is presented.
    drive(0, 0, 1, 1, 5'd12, RES_ALU, 3'd0, 32'h0000_ABCD, 32'h0, 32'h0);
    check("pre_rst_we", rf_we, 1);
    reset_mid();

    // Small counter wraps from all-ones to zero.
    for (int k = 0; k < 8; k++)
      drive(0, 0, 1, 1, 5'(k + 1), RES_ALU, 3'd0, 32'(k), 32'h0, 32'h0);
    check("small_instret_allones", s_instret, 7);
    drive(0, 0, 0, 0, 5'd0, RES_ALU, 3'd0, 32'h0, 32'h0, 32'h0);
    check("small_instret_wrap0", s_instret, 0);
    check("instret_eight", instret, 8);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rrd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r    = int'($urandom_range(0, 15));
      rsrc = (r < 6) ? RES_ALU : (r < 12) ? RES_MEM : (r < 15) ? RES_PC4 : RES_RSVD;
      r    = int'($urandom_range(0, 9));
      case (r)
        0, 1:    rf3 = F3_LB;
        2, 3:    rf3 = F3_LH;
        4:       rf3 = F3_LW;
        5, 6:    rf3 = F3_LBU;
        7:       rf3 = F3_LHU;
        8:       rf3 = 3'b011;
        default: rf3 = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
      endcase
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) != 0, $urandom_range(0, 4) != 0,
            rrd, rsrc, rf3, $urandom, $urandom, $urandom);
      if (n == 300) reset_mid();
    end

    repeat (3) drive(0, 0, 0, 0, 5'd0, RES_ALU, 3'd0, 32'h0, 32'h0, 32'h0);
    #6;
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
